// File: rtl/fifo_rr_wr_arbiter_if.sv
// Interface between the round-robin write arbiter, its producers, the FIFO and its consumer.
// The arbiter attaches through the slave modport; the environment drives through master.
interface fifo_rr_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          fifo_wr_en;
  logic [FIFO_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_full;
  logic                          fifo_almostfull;
  logic                          fifo_empty;
  logic                          fifo_overflow;
  logic                          fifo_underflow;
  logic                          cons_rd_en;
  logic                          fifo_rd_en;
  logic                          flush_req;
  logic                          flush_done;
  logic                          err_overflow;
  logic                          err_underflow;
  logic                          err_clr;

  modport slave (
    input  req, req_data, fifo_full, fifo_almostfull, fifo_empty,
           fifo_overflow, fifo_underflow, cons_rd_en, flush_req, err_clr,
    output gnt, fifo_wr_en, fifo_data_in, fifo_rd_en, flush_done,
           err_overflow, err_underflow
  );

  modport master (
    output req, req_data, fifo_full, fifo_almostfull, fifo_empty,
           fifo_overflow, fifo_underflow, cons_rd_en, flush_req, err_clr,
    input  gnt, fifo_wr_en, fifo_data_in, fifo_rd_en, flush_done,
           err_overflow, err_underflow
  );
endinterface

// File: rtl/fifo_rr_wr_arbiter.sv
// Round-robin write arbiter / sequencer for the synchronous FIFO, with flush and sticky errors.
// Define ARB_BURST_EN to let a winner keep priority for up to MAX_BURST consecutive grants.
module fifo_rr_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input logic                clk,
  input logic                rst_n,
  fifo_rr_wr_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    FLUSH   = 2'd1,
    FLUSHED = 2'd2
  } state_t;

  if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_BURST < 1) begin : g_bad_params
    $error("fifo_rr_wr_arbiter: parameter out of legal range");
  end

  state_t                state, state_nxt;
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      found_idx, pick;
  logic                  found, pick_valid;
  logic                  can_issue, grant;
  logic                  rd_c;
  logic                  wr_en_q, flush_done_q, err_ov_q, err_un_q;
  logic [FIFO_WIDTH-1:0] data_q;

  // The in-flight write is counted against almostfull so the FIFO can never be over-written.
  assign can_issue = !bus.fifo_full && !(bus.fifo_almostfull && wr_en_q);

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    int idx;
    found     = 1'b0;
    found_idx = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req[idx]) begin
        found     = 1'b1;
        found_idx = PTR_W'(idx);
      end
    end
  end

`ifdef ARB_BURST_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic [CNT_W-1:0] burst_cnt;
  logic [PTR_W-1:0] holder;
  logic             keep;

  // The holder outranks the rotation while it still requests and has burst budget left.
  assign keep = (burst_cnt != '0) && (burst_cnt < CNT_W'(MAX_BURST)) && bus.req[holder];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= '0;
      holder    <= '0;
    end else if (state != ARB || bus.flush_req) begin
      burst_cnt <= '0;
    end else if (grant) begin
      if (keep) begin
        burst_cnt <= burst_cnt + 1'b1;
      end else begin
        burst_cnt <= CNT_W'(1);
        holder    <= pick;
      end
    end else if (!keep) begin
      burst_cnt <= '0;
    end
  end
`endif

  always_comb begin
    pick       = found_idx;
    pick_valid = found;
`ifdef ARB_BURST_EN
    if (keep) begin
      pick       = holder;
      pick_valid = 1'b1;
    end
`endif
  end

  assign grant = (state == ARB) && !bus.flush_req && can_issue && pick_valid;

  always_comb begin
    state_nxt = state;
    rd_c      = 1'b0;
    case (state)
      ARB: begin
        rd_c = bus.cons_rd_en;
        if (bus.flush_req) state_nxt = FLUSH;
      end
      FLUSH: begin
        rd_c = !bus.fifo_empty;
        // Wait for the last in-flight write to land before calling the FIFO drained.
        if (bus.fifo_empty && !wr_en_q) state_nxt = FLUSHED;
      end
      FLUSHED: begin
        if (!bus.flush_req) state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ARB;
      rr_ptr       <= '0;
      wr_en_q      <= 1'b0;
      data_q       <= '0;
      flush_done_q <= 1'b0;
      err_ov_q     <= 1'b0;
      err_un_q     <= 1'b0;
    end else begin
      state        <= state_nxt;
      flush_done_q <= (state_nxt == FLUSHED);
      wr_en_q      <= grant;
      if (grant) begin
        data_q <= bus.req_data[pick*FIFO_WIDTH +: FIFO_WIDTH];
        rr_ptr <= (pick == PTR_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
      end
      if (bus.fifo_overflow)  err_ov_q <= 1'b1;
      else if (bus.err_clr)   err_ov_q <= 1'b0;
      if (bus.fifo_underflow) err_un_q <= 1'b1;
      else if (bus.err_clr)   err_un_q <= 1'b0;
    end
  end

  assign bus.gnt           = (grant ? (NUM_REQ'(1) << pick) : '0) & {NUM_REQ{rst_n}};
  assign bus.fifo_rd_en    = rd_c & rst_n;
  assign bus.fifo_wr_en    = wr_en_q;
  assign bus.fifo_data_in  = data_q;
  assign bus.flush_done    = flush_done_q;
  assign bus.err_overflow  = err_ov_q;
  assign bus.err_underflow = err_un_q;
endmodule

// File: tb/tb_fifo_rr_wr_arbiter.sv
// Self-checking bench for fifo_rr_wr_arbiter: a small FIFO occupancy model as environment
// plus a rule-level reference model of arbitration, flush and error flags.
module tb_fifo_rr_wr_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int W         = 16;
  localparam int DEPTH     = 8;
  localparam int MAX_BURST = 4;

  logic clk;
  logic rst_n;

  fifo_rr_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .FIFO_WIDTH(W)) bus ();

  fifo_rr_wr_arbiter #(.NUM_REQ(NUM_REQ), .FIFO_WIDTH(W), .MAX_BURST(MAX_BURST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // FIFO environment: occupancy counter with registered overflow/underflow pulses
  int f_cnt;
  bit f_ov, f_un, ov_inject, preload_go;
  int preload_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_cnt <= 0;
      f_ov  <= 1'b0;
      f_un  <= 1'b0;
    end else begin
      f_ov <= bus.fifo_wr_en && (f_cnt == DEPTH);
      f_un <= bus.fifo_rd_en && (f_cnt == 0);
      if (preload_go) f_cnt <= preload_cnt;
      else f_cnt <= f_cnt + ((bus.fifo_wr_en && f_cnt != DEPTH) ? 1 : 0)
                          - ((bus.fifo_rd_en && f_cnt != 0) ? 1 : 0);
    end
  end

  assign bus.fifo_full       = (f_cnt == DEPTH);
  assign bus.fifo_almostfull = (f_cnt >= DEPTH - 1);
  assign bus.fifo_empty      = (f_cnt == 0);
  assign bus.fifo_overflow   = f_ov | ov_inject;
  assign bus.fifo_underflow  = f_un;

  // Reference model state
  int           m_ptr;
  bit           m_wr, m_drain, m_drained, m_eov, m_eun;
  logic [W-1:0] m_data;
`ifdef ARB_BURST_EN
  int           m_holder, m_bcnt;
`endif
  int           last_win;

  // Observed and expected values of one cycle
  logic [NUM_REQ-1:0] o_gnt, e_gnt;
  logic [W-1:0]       o_data, e_data;
  logic               o_rd, o_wr, o_done, o_eov, o_eun;
  logic               e_rd, e_wr, e_done, e_eov, e_eun;

  task automatic model_reset();
    m_ptr = 0; m_wr = 0; m_data = '0; m_drain = 0; m_drained = 0; m_eov = 0; m_eun = 0;
`ifdef ARB_BURST_EN
    m_holder = 0; m_bcnt = 0;
`endif
  endtask

  // One clock: sample outputs, form expectations, advance the model across the edge.
  task automatic step();
    int  win;
    bit  can, n_drain, n_drained, keep;
    #1;
    o_gnt = bus.gnt; o_rd = bus.fifo_rd_en; o_wr = bus.fifo_wr_en; o_data = bus.fifo_data_in;
    o_done = bus.flush_done; o_eov = bus.err_overflow; o_eun = bus.err_underflow;
    e_wr = m_wr; e_data = m_data; e_done = m_drained; e_eov = m_eov; e_eun = m_eun;
    win  = -1;
    keep = 0;
`ifdef ARB_BURST_EN
    keep = (m_bcnt > 0) && (m_bcnt < MAX_BURST) && bus.req[m_holder];
`endif
    can = !bus.fifo_full && !(bus.fifo_almostfull && m_wr);
    if (m_drained) e_rd = 0;
    else if (m_drain) e_rd = !bus.fifo_empty;
    else begin
      e_rd = bus.cons_rd_en;
      if (!bus.flush_req && can) begin
`ifdef ARB_BURST_EN
        if (keep) win = m_holder;
`endif
        for (int k = 0; k < NUM_REQ; k++)
          if (win < 0 && bus.req[(m_ptr + k) % NUM_REQ]) win = (m_ptr + k) % NUM_REQ;
      end
    end
    e_gnt    = (win >= 0) ? (NUM_REQ'(1) << win) : '0;
    last_win = win;

    n_drain = m_drain; n_drained = m_drained;
    if (m_drained) begin
      if (!bus.flush_req) n_drained = 0;
    end else if (m_drain) begin
      if (bus.fifo_empty && !m_wr) begin n_drain = 0; n_drained = 1; end
    end else if (bus.flush_req) n_drain = 1;

    @(posedge clk);
`ifdef ARB_BURST_EN
    if (m_drain || m_drained || bus.flush_req) m_bcnt = 0;
    else if (win >= 0) begin
      if (keep) m_bcnt++;
      else begin m_holder = win; m_bcnt = 1; end
    end else if (!keep) m_bcnt = 0;
`endif
    m_wr = (win >= 0);
    if (win >= 0) begin
      m_data = bus.req_data[win*W +: W];
      m_ptr  = (win + 1) % NUM_REQ;
    end
    if (bus.fifo_overflow) m_eov = 1; else if (bus.err_clr) m_eov = 0;
    if (bus.fifo_underflow) m_eun = 1; else if (bus.err_clr) m_eun = 0;
    m_drain = n_drain; m_drained = n_drained;
    @(negedge clk);
    if (win >= 0) bus.req_data[win*W +: W] = W'($urandom);
  endtask

  task automatic idle_inputs();
    bus.req = '0; bus.cons_rd_en = 0; bus.flush_req = 0; bus.err_clr = 0;
    ov_inject = 0; preload_go = 0; preload_cnt = 0;
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*W +: W] = W'($urandom);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1;
  endtask

  task automatic preload(input int cnt);
    preload_cnt = cnt;
    preload_go  = 1;
    step();
    preload_go  = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.req = '1; bus.cons_rd_en = 1;
    rst_n = 0;
    @(negedge clk); #1;
    n_vec += 7;
    if (bus.gnt !== '0)          begin n_err++; $display("FAIL reset_gnt: got %b want 0", bus.gnt); end
    if (bus.fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b want 0", bus.fifo_rd_en); end
    if (bus.fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %b want 0", bus.fifo_wr_en); end
    if (bus.fifo_data_in !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", bus.fifo_data_in); end
    if (bus.flush_done !== 1'b0) begin n_err++; $display("FAIL reset_flush_done: got %b want 0", bus.flush_done); end
    if (bus.err_overflow !== 1'b0)  begin n_err++; $display("FAIL reset_err_ov: got %b want 0", bus.err_overflow); end
    if (bus.err_underflow !== 1'b0) begin n_err++; $display("FAIL reset_err_un: got %b want 0", bus.err_underflow); end
    @(negedge clk);
    model_reset();
    rst_n = 1;
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.req = '1; bus.cons_rd_en = 1;
    for (int k = 0; k < 12; k++) begin
      step();
      n_vec += 2;
      if (o_gnt !== (NUM_REQ'(1) << (k % NUM_REQ))) begin
        n_err++; $display("FAIL rr_gnt cycle %0d: got %b want %b", k, o_gnt, NUM_REQ'(1) << (k % NUM_REQ));
      end
      if (o_data !== e_data) begin n_err++; $display("FAIL rr_data cycle %0d: got %h want %h", k, o_data, e_data); end
      if (k >= 1) begin
        n_vec++;
        if (o_wr !== 1'b1) begin n_err++; $display("FAIL rr_wr_en cycle %0d: got %b want 1", k, o_wr); end
      end
    end
    bus.err_clr = 1; step(); bus.err_clr = 0;
  endtask

  task automatic test_fill();
    int  n_g;
    bit  saw_ov;
    do_reset();
    n_g = 0; saw_ov = 0;
    bus.req = 4'b0101;
    for (int k = 0; k < 14; k++) begin
      step();
      if (o_gnt != '0) n_g++;
      if (bus.fifo_overflow) saw_ov = 1;
      n_vec++;
      if (o_gnt !== e_gnt) begin n_err++; $display("FAIL fill_gnt cycle %0d: got %b want %b", k, o_gnt, e_gnt); end
    end
    n_vec += 4;
    if (n_g != 8)     begin n_err++; $display("FAIL fill_grants: got %0d want 8", n_g); end
    if (f_cnt != 8)   begin n_err++; $display("FAIL fill_count: got %0d want 8", f_cnt); end
    if (saw_ov)       begin n_err++; $display("FAIL fill_overflow: got 1 want 0"); end
    if (o_eov !== 0)  begin n_err++; $display("FAIL fill_err_ov: got %b want 0", o_eov); end
  endtask

  task automatic test_almost_full();
    int n_g;
    do_reset();
    preload(6);
    n_g = 0;
    bus.req = 4'b0001;
    repeat (6) begin
      step();
      if (o_gnt != '0) n_g++;
    end
    n_vec += 2;
    if (n_g != 2)   begin n_err++; $display("FAIL af_grants: got %0d want 2", n_g); end
    if (f_cnt != 8) begin n_err++; $display("FAIL af_count: got %0d want 8", f_cnt); end
  endtask

  task automatic test_flush();
    int n_rd, n_g;
    do_reset();
    preload(4);
    bus.req = 4'b0010;
    step();
    n_vec++;
    if (o_gnt !== 4'b0010) begin n_err++; $display("FAIL flush_pre_gnt: got %b want 0010", o_gnt); end
    bus.req = '1; bus.flush_req = 1;
    n_rd = 0; n_g = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (o_rd) n_rd++;
      if (o_gnt != '0) n_g++;
      if (o_done) break;
    end
    n_vec += 3;
    if (n_rd != 5)    begin n_err++; $display("FAIL flush_rd_cycles: got %0d want 5", n_rd); end
    if (n_g != 0)     begin n_err++; $display("FAIL flush_grants: got %0d want 0", n_g); end
    if (o_done !== 1) begin n_err++; $display("FAIL flush_done_timeout: got %b want 1", o_done); end
    repeat (2) begin
      step();
      n_vec += 2;
      if (o_done !== 1) begin n_err++; $display("FAIL flush_done_hold: got %b want 1", o_done); end
      if (o_rd !== 0)   begin n_err++; $display("FAIL flush_rd_hold: got %b want 0", o_rd); end
    end
    bus.flush_req = 0;
    step();
    step();
    n_vec++;
    if (o_gnt !== 4'b0100) begin n_err++; $display("FAIL flush_resume_gnt: got %b want 0100", o_gnt); end
  endtask

  task automatic test_errors();
    do_reset();
    bus.cons_rd_en = 1; step();
    bus.cons_rd_en = 0; step();
    repeat (2) begin
      step();
      n_vec++;
      if (o_eun !== 1) begin n_err++; $display("FAIL err_un_set: got %b want 1", o_eun); end
    end
    bus.err_clr = 1; step();
    bus.err_clr = 0; step();
    n_vec++;
    if (o_eun !== 0) begin n_err++; $display("FAIL err_un_clr: got %b want 0", o_eun); end
    ov_inject = 1; bus.err_clr = 1; step();
    ov_inject = 0; bus.err_clr = 0; step();
    n_vec++;
    if (o_eov !== 1) begin n_err++; $display("FAIL err_ov_set_wins: got %b want 1", o_eov); end
  endtask

  task automatic test_random(input int cycles);
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      bus.cons_rd_en = ($urandom_range(0, 1) == 1);
      bus.err_clr    = ($urandom_range(0, 15) == 0);
      ov_inject      = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 19) == 0) bus.flush_req = !bus.flush_req;
      step();
      n_vec += 7;
      if (o_gnt !== e_gnt)   begin n_err++; $display("FAIL rand_gnt %0d: got %b want %b", c, o_gnt, e_gnt); end
      if (o_rd !== e_rd)     begin n_err++; $display("FAIL rand_rd_en %0d: got %b want %b", c, o_rd, e_rd); end
      if (o_wr !== e_wr)     begin n_err++; $display("FAIL rand_wr_en %0d: got %b want %b", c, o_wr, e_wr); end
      if (o_data !== e_data) begin n_err++; $display("FAIL rand_data %0d: got %h want %h", c, o_data, e_data); end
      if (o_done !== e_done) begin n_err++; $display("FAIL rand_flush_done %0d: got %b want %b", c, o_done, e_done); end
      if (o_eov !== e_eov)   begin n_err++; $display("FAIL rand_err_ov %0d: got %b want %b", c, o_eov, e_eov); end
      if (o_eun !== e_eun)   begin n_err++; $display("FAIL rand_err_un %0d: got %b want %b", c, o_eun, e_eun); end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (last_win == i) begin
          if ($urandom_range(0, 1) == 0) bus.req[i] = 0;
        end else if (!bus.req[i] && $urandom_range(0, 9) < 4) begin
          bus.req[i] = 1;
          bus.req_data[i*W +: W] = W'($urandom);
        end
      end
    end
    bus.flush_req = 0;
  endtask

  task automatic test_async_reset();
    bus.req = '1; bus.cons_rd_en = 1; bus.flush_req = 0;
    repeat (3) step();
    rst_n = 0;
    #1;
    n_vec += 4;
    if (bus.gnt !== '0)          begin n_err++; $display("FAIL areset_gnt: got %b want 0", bus.gnt); end
    if (bus.fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL areset_rd_en: got %b want 0", bus.fifo_rd_en); end
    if (bus.fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL areset_wr_en: got %b want 0", bus.fifo_wr_en); end
    if (bus.fifo_data_in !== '0) begin n_err++; $display("FAIL areset_data: got %h want 0", bus.fifo_data_in); end
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1;
    step();
    n_vec++;
    if (o_gnt !== 4'b0001) begin n_err++; $display("FAIL areset_first_gnt: got %b want 0001", o_gnt); end
  endtask

`ifdef ARB_BURST_EN
  task automatic test_burst();
    int exp_w[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    do_reset();
    bus.cons_rd_en = 1; bus.req = 4'b0011;
    for (int k = 0; k < 12; k++) begin
      step();
      n_vec++;
      if (o_gnt !== (NUM_REQ'(1) << exp_w[k])) begin
        n_err++; $display("FAIL burst_gnt %0d: got %b want %b", k, o_gnt, NUM_REQ'(1) << exp_w[k]);
      end
    end
    do_reset();
    bus.cons_rd_en = 1; bus.req = 4'b0011;
    repeat (2) begin
      step();
      n_vec++;
      if (o_gnt !== 4'b0001) begin n_err++; $display("FAIL burst_hold_gnt: got %b want 0001", o_gnt); end
    end
    bus.req = 4'b0010;
    step();
    n_vec++;
    if (o_gnt !== 4'b0010) begin n_err++; $display("FAIL burst_drop_gnt: got %b want 0010", o_gnt); end
  endtask
`endif

  initial begin
    rst_n = 0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_fill();
    test_almost_full();
    test_flush();
    test_errors();
`ifdef ARB_BURST_EN
    test_burst();
`endif
    test_random(400);
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1);
  end
endmodule

// File: doc/fifo_rr_wr_arbiter.md
Name: fifo_rr_wr_arbiter

Overview:
Round-robin write arbiter and sequencer in front of the team's synchronous FIFO.
- Shares the FIFO write port among NUM_REQ producers using a valid/grant handshake.
- Drives registered wr_en/data_in to the FIFO, and uses full/almostfull to guarantee the FIFO never overflows.
- Passes consumer reads through to the FIFO, and provides a flush sequence that drains the FIFO to empty.

Parameters:
NUM_REQ, 4, number of producers; legal range 2..16; need not be a power of 2.
FIFO_WIDTH, 16, data width; must match the FIFO.
MAX_BURST, 4, maximum consecutive grants to one producer; used only when ARB_BURST_EN is defined.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-producer request; producer holds req and its data until granted
req_data  in  NUM_REQ*FIFO_WIDTH  packed producer data; slice i is bits [i*FIFO_WIDTH +: FIFO_WIDTH]
gnt  out  NUM_REQ  one-hot (or zero) combinational accept; data of the granted producer is taken at this edge
fifo_wr_en  out  1  registered FIFO write enable
fifo_data_in  out  FIFO_WIDTH  registered FIFO write data
fifo_full  in  1  FIFO full flag
fifo_almostfull  in  1  FIFO almostfull flag
fifo_empty  in  1  FIFO empty flag
fifo_overflow  in  1  FIFO overflow flag
fifo_underflow  in  1  FIFO underflow flag
cons_rd_en  in  1  consumer read request
fifo_rd_en  out  1  FIFO read enable (combinational)
flush_req  in  1  level request to drain the FIFO
flush_done  out  1  registered; high while in state FLUSHED
err_overflow  out  1  sticky flag: FIFO overflow was seen
err_underflow  out  1  sticky flag: FIFO underflow was seen
err_clr  in  1  clears both sticky flags

Behaviour:
- Reset (asynchronous, also when asserted mid-operation):
  - state=ARB, rr_ptr=0, burst_cnt=0.
  - fifo_wr_en=0, fifo_data_in=0, flush_done=0, err_*=0.
  - gnt and fifo_rd_en are forced to 0 while rst_n=0.
- can_issue = !fifo_full && !(fifo_almostfull && fifo_wr_en).
  - This accounts for the one write already in flight, so at most DEPTH entries are ever written. Reads are ignored, which is conservative.
- State ARB:
  - If flush_req=1: go to FLUSH; gnt=0 in that cycle.
  - Else if can_issue and req!=0: the winner is the first i with req[i]=1, searching cyclically from rr_ptr.
    - gnt[winner]=1.
    - At the edge: fifo_wr_en<=1, fifo_data_in<=slice(winner), rr_ptr<=winner+1, wrapping from NUM_REQ-1 to 0.
  - Else: gnt=0, fifo_wr_en<=0, fifo_data_in holds its value.
  - fifo_rd_en = cons_rd_en (pass-through).
- State FLUSH:
  - gnt=0, fifo_wr_en<=0.
  - fifo_rd_en = !fifo_empty; cons_rd_en is ignored.
  - Go to FLUSHED when fifo_empty=1 and fifo_wr_en=0, so that a write already in flight is drained too.
- State FLUSHED:
  - flush_done=1, gnt=0, fifo_rd_en=0.
  - Return to ARB when flush_req=0.
  - rr_ptr is preserved across the whole flush.
- Latency: a grant in cycle t gives fifo_wr_en=1 with that data in cycle t+1. Full throughput is one grant per cycle.
- Sticky error flags:
  - err_overflow<=1 at an edge where fifo_overflow=1; err_underflow likewise with fifo_underflow.
  - err_clr clears both flags; a set in the same cycle wins over the clear.
- FLUSH never underflows the FIFO. In ARB, an underflow is possible only through cons_rd_en.
- States are encoded as a 2-bit enum: ARB=0, FLUSH=1, FLUSHED=2.

Optional Feature:
Macro ARB_BURST_EN.
- Defined:
  - The last winner keeps priority while its req stays high, up to MAX_BURST consecutive grants. burst_cnt counts the grants.
  - Cycles with can_issue=0 do not break the burst.
  - The burst ends when the holder drops req or burst_cnt reaches MAX_BURST. rr_ptr then moves to holder+1 and burst_cnt resets to 0.
  - FLUSH and reset also end the burst.
- Undefined: pure round-robin; MAX_BURST is unused and burst_cnt is not built.

Test Plan:
- Reset; req=4'b1111 held; cons_rd_en=1 throughout -> gnt 0,1,2,3,0,... one per cycle; fifo_wr_en=1 each cycle from cycle 2; data order matches grant order.
- DEPTH=8 FIFO, no reads, req=4'b0101 held -> exactly 8 grants alternating 0,2; then gnt=0 and fifo_full=1; fifo_overflow stays 0; err_overflow=0.
- FIFO at count 6; req0 held; cons_rd_en=0 -> exactly 2 more writes, no third grant, FIFO stays at count 8.
- 5 entries in FIFO; flush_req=1 while req=1111 -> no gnt; fifo_rd_en high for 5 cycles; flush_done=1 after empty and held; flush_req=0 -> ARB resumes at the saved rr_ptr.
- FIFO empty; cons_rd_en=1 for one cycle -> fifo_underflow, then err_underflow=1 held; err_clr pulse -> err_underflow returns to 0.
- ARB_BURST_EN with MAX_BURST=4; req0 and req1 held -> gnt0 x4, gnt1 x4, gnt0 x4; req0 dropped after 2 grants -> gnt1 follows immediately.
